path_streamer: RTL

//  Back end of the path planner. Walks a predecessor table (filled by the

---
 rtl/path_streamer_if.sv | 40 ++++
 rtl/path_streamer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/path_streamer_if.sv
// Bus bundle between the planner, path_streamer and path_mapping.
// The replay strobe exists only when PATH_REPLAY_EN is defined.
interface path_streamer_if #(
  parameter int NODE_W = 5
);
  // Every signal is a single-cycle level; there is no backpressure and
  // path_input/path_planned form a valid-only stream that path_mapping always accepts.
  logic              pred_we;
  logic [NODE_W-1:0] pred_addr;
  logic [NODE_W-1:0] pred_data;
  logic              start;
  logic [NODE_W-1:0] start_node;
  logic [NODE_W-1:0] end_node;
`ifdef PATH_REPLAY_EN
  logic              replay;
`endif
  logic              path_input;
  logic [NODE_W-1:0] path_planned;
  logic [NODE_W-1:0] path_len;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        dbg_state;

  modport master (
`ifdef PATH_REPLAY_EN
    output replay,
`endif
    output pred_we, pred_addr, pred_data, start, start_node, end_node,
    input  path_input, path_planned, path_len, busy, done, error, dbg_state
  );

  modport slave (
`ifdef PATH_REPLAY_EN
    input  replay,
`endif
    input  pred_we, pred_addr, pred_data, start, start_node, end_node,
    output path_input, path_planned, path_len, busy, done, error, dbg_state
  );
endinterface

// File: rtl/path_streamer.sv
// Walks the predecessor table from end_node back to start_node, then streams the path forward.
// Optional feature macro: PATH_REPLAY_EN (re-stream the last path without a walk).
module path_streamer #(
  parameter int NODE_W    = 5,
  parameter int NUM_NODES = 30,
  parameter int MAX_PATH  = 16,
  parameter int NO_PRED   = 31
) (
  input  logic            clk_3125KHz,
  input  logic            rst_n,
  path_streamer_if.slave  bus
);
  localparam int SP_W  = $clog2(MAX_PATH + 1);
  localparam int IDX_W = $clog2(MAX_PATH);

  typedef enum logic [1:0] {IDLE, WALK, EMIT, DONE} state_t;

  state_t            state;
  logic [NODE_W-1:0] cur;
  logic [NODE_W-1:0] start_q;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_m1;
  logic [NODE_W-1:0] stack    [MAX_PATH];
  logic [NODE_W-1:0] pred_tbl [NUM_NODES];
  logic [NODE_W-1:0] pred_cur;
  logic              nodes_bad;
  logic              pred_bad;

  logic              path_input_q;
  logic [NODE_W-1:0] path_planned_q;
  logic [NODE_W-1:0] path_len_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
`ifdef PATH_REPLAY_EN
  logic              path_valid;
`endif

  assign sp_m1     = sp - SP_W'(1);
  assign pred_cur  = pred_tbl[cur];
  assign nodes_bad = (bus.start_node >= NODE_W'(NUM_NODES)) ||
                     (bus.end_node   >= NODE_W'(NUM_NODES));
  assign pred_bad  = (pred_cur == NODE_W'(NO_PRED)) || (pred_cur >= NODE_W'(NUM_NODES));

  assign bus.path_input   = path_input_q;
  assign bus.path_planned = path_planned_q;
  assign bus.path_len     = path_len_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.dbg_state    = state;

  // The table is only writable while idle so a walk or stream never sees it change.
  always_ff @(posedge clk_3125KHz) begin
    if (state == IDLE && bus.pred_we && bus.pred_addr < NODE_W'(NUM_NODES))
      pred_tbl[bus.pred_addr] <= bus.pred_data;
  end

  // Stack is only pushed during WALK, where sp never exceeds MAX_PATH-1.
  always_ff @(posedge clk_3125KHz) begin
    if (state == WALK)
      stack[sp[IDX_W-1:0]] <= cur;
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur            <= '0;
      start_q        <= '0;
      sp             <= '0;
      path_input_q   <= 1'b0;
      path_planned_q <= '0;
      path_len_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef PATH_REPLAY_EN
      path_valid     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // busy trails the state by one cycle so it covers the whole stream window.
      busy_q <= (state == WALK) || (state == EMIT);
      case (state)
        IDLE: begin
          path_input_q <= 1'b0;
          if (bus.start) begin
            cur     <= bus.end_node;
            start_q <= bus.start_node;
            sp      <= '0;
            error_q <= nodes_bad;
`ifdef PATH_REPLAY_EN
            path_valid <= 1'b0;
`endif
            if (!nodes_bad)
              state <= WALK;
          end
`ifdef PATH_REPLAY_EN
          else if (bus.replay && path_valid && !error_q) begin
            // The stack is never overwritten by EMIT, so rewinding sp replays it.
            sp    <= SP_W'(path_len_q);
            state <= EMIT;
          end
`endif
        end
        WALK: begin
          sp <= sp + SP_W'(1);
          if (cur == start_q) begin
            path_len_q <= NODE_W'(sp + SP_W'(1));
            state      <= EMIT;
`ifdef PATH_REPLAY_EN
            path_valid <= 1'b1;
`endif
          end else if (pred_bad || sp == SP_W'(MAX_PATH - 1)) begin
            error_q <= 1'b1;
            state   <= IDLE;
          end else begin
            cur <= pred_cur;
          end
        end
        EMIT: begin
          path_input_q   <= 1'b1;
          path_planned_q <= stack[sp_m1[IDX_W-1:0]];
          sp             <= sp_m1;
          if (sp_m1 == '0)
            state <= DONE;
        end
        DONE: begin
          path_input_q <= 1'b0;
          done_q       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
